// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: shared widths and FSM state encoding for the
// count_sequencer block and its slot counter.
package count_sequencer_pkg;

  localparam int COUNT_W = 3;
  localparam int REPS_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/count_sequencer_slot_counter.sv
// slot_counter: COUNT_W-bit up counter that rolls back to 0 after reaching
// a terminal value.
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   clr_i  in   synchronous clear (wins over en_i)
//   en_i   in   advance one slot this cycle
//   term_i in   terminal value; the count after term_i is 0
//   cnt_o  out  current count (registered)
//   tc_o   out  high while cnt_o == term_i
module slot_counter
  import count_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [COUNT_W-1:0] term_i,
  output logic [COUNT_W-1:0] cnt_o,
  output logic               tc_o
);

  logic [COUNT_W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == term_i);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: runs a slot count 0..limit for a number of passes.
// limit/reps are captured on start; reps == 0 runs until aborted.
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   run request, only looked at in IDLE
//   pause  in   level; freezes the count (RUN -> HOLD)
//   abort  in   cancel back to IDLE (no effect in IDLE, also blocks start)
//   limit  in   terminal count, latched at start
//   reps   in   pass count, latched at start (0 = continuous)
//   count  out  current slot count
//   busy   out  RUN or HOLD
//   wrap   out  one-cycle pulse on the cycle count returns to 0 from limit
//   done   out  high in FINISH
//   state  out  FSM state encoding
// Every output is a register or a decode of the registered state.
module count_sequencer
  import count_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [COUNT_W-1:0] limit,
  input  logic [REPS_W-1:0]  reps,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               wrap,
  output logic               done,
  output logic [1:0]         state
);

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  limit_q, limit_d;
  logic [REPS_W-1:0]   reps_q,  reps_d;
  logic [REPS_W-1:0]   pass_q,  pass_d;
  logic                wrap_q,  wrap_d;
  logic [REPS_W-1:0]   pass_inc;
  logic                cnt_en, cnt_clr, cnt_tc;

  slot_counter u_slot (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (limit_q),
    .cnt_o  (count),
    .tc_o   (cnt_tc)
  );

  // Saturating so continuous runs never alias back to a small pass count.
  assign pass_inc = (pass_q == '1) ? pass_q : pass_q + {{(REPS_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    reps_d  = reps_q;
    pass_d  = pass_q;
    wrap_d  = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start && !abort) begin
          state_d = RUN;
          limit_d = limit;
          reps_d  = reps;
          pass_d  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          pass_d  = '0;
        end else if (pause) begin
          state_d = HOLD;
        end else begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            wrap_d = 1'b1;
            pass_d = pass_inc;
            if (reps_q != '0 && pass_inc == reps_q) state_d = FINISH;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          pass_d  = '0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      FINISH: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
        if (abort) pass_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      limit_q <= '0;
      reps_q  <= '0;
      pass_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      reps_q  <= reps_d;
      pass_q  <= pass_d;
      wrap_q  <= wrap_d;
    end
  end

  assign state = state_q;
  assign wrap  = wrap_q;
  assign busy  = (state_q == RUN) || (state_q == HOLD);
  assign done  = (state_q == FINISH);

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort;
  logic [2:0] limit;
  logic [3:0] reps;
  logic [2:0] count;
  logic       busy, wrap, done;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2, S_FIN = 2'd3;

  count_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .pause (pause),
    .abort (abort),
    .limit (limit),
    .reps  (reps),
    .count (count),
    .busy  (busy),
    .wrap  (wrap),
    .done  (done),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // busy/done follow from the expected state.
  task automatic chk(input string tag, input logic [1:0] est, input logic [2:0] ec, input logic ew);
    logic [7:0] obs, exp;
    obs = {state, count, wrap, busy, done};
    exp = {est, ec, ew, (est == S_RUN) || (est == S_HOLD), est == S_FIN};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: {state,count,wrap,busy,done} got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] c;
    logic       w;
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; limit = '0; reps = '0;
    tick(); tick();
    chk("reset", S_IDLE, 3'd0, 1'b0);

    // limit=5 reps=2; start on first edge out of reset
    reset = 1'b0; start = 1'b1; limit = 3'd5; reps = 4'd2;
    tick(); start = 1'b0;
    chk("t1_start", S_RUN, 3'd0, 1'b0);
    limit = 3'd3; reps = 4'd7;  // must not affect the latched run
    for (int k = 1; k <= 5; k++) begin tick(); chk($sformatf("t1_p1_%0d", k), S_RUN, 3'(k), 1'b0); end
    tick(); chk("t1_wrap1", S_RUN, 3'd0, 1'b1);
    for (int k = 1; k <= 5; k++) begin tick(); chk($sformatf("t1_p2_%0d", k), S_RUN, 3'(k), 1'b0); end
    tick(); chk("t1_finish", S_FIN, 3'd0, 1'b1);
    tick(); chk("t1_idle", S_IDLE, 3'd0, 1'b0);

    // limit=3 reps=0 with a 3-cycle pause at count 2
    start = 1'b1; limit = 3'd3; reps = 4'd0;
    tick(); start = 1'b0;
    chk("t2_start", S_RUN, 3'd0, 1'b0);
    tick(); chk("t2_c1", S_RUN, 3'd1, 1'b0);
    tick(); chk("t2_c2", S_RUN, 3'd2, 1'b0);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); chk($sformatf("t2_hold%0d", k), S_HOLD, 3'd2, 1'b0); end
    pause = 1'b0;
    tick(); chk("t2_resume", S_RUN, 3'd2, 1'b0);
    tick(); chk("t2_c3", S_RUN, 3'd3, 1'b0);
    tick(); chk("t2_wrap", S_RUN, 3'd0, 1'b1);
    // 18 more passes: past pass-counter saturation, never finishes
    c = 3'd0;
    for (int k = 0; k < 72; k++) begin
      w = (c == 3'd3);
      c = w ? 3'd0 : c + 3'd1;
      tick(); chk($sformatf("t2_cont%0d", k), S_RUN, c, w);
    end
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("t2_abort", S_IDLE, 3'd0, 1'b0);

    // limit=7 reps=1, start while busy ignored, abort at count 4
    start = 1'b1; limit = 3'd7; reps = 4'd1;
    tick(); chk("t3_start", S_RUN, 3'd0, 1'b0);
    limit = 3'd2;  // start stays high, new limit must be ignored
    tick(); chk("t3_c1", S_RUN, 3'd1, 1'b0);
    tick(); chk("t3_c2", S_RUN, 3'd2, 1'b0);
    start = 1'b0;
    tick(); chk("t3_c3", S_RUN, 3'd3, 1'b0);
    tick(); chk("t3_c4", S_RUN, 3'd4, 1'b0);
    abort = 1'b1;
    tick(); chk("t3_abort", S_IDLE, 3'd0, 1'b0);
    // abort + start in IDLE stays IDLE
    start = 1'b1; limit = 3'd1; reps = 4'd1;
    tick(); chk("t3_abort_start", S_IDLE, 3'd0, 1'b0);
    abort = 1'b0; start = 1'b0;
    tick(); chk("t3_idle", S_IDLE, 3'd0, 1'b0);

    // limit=0 reps=3: wrap every RUN cycle
    start = 1'b1; limit = 3'd0; reps = 4'd3;
    tick(); start = 1'b0;
    chk("t4_start", S_RUN, 3'd0, 1'b0);
    tick(); chk("t4_w1", S_RUN, 3'd0, 1'b1);
    tick(); chk("t4_w2", S_RUN, 3'd0, 1'b1);
    tick(); chk("t4_fin", S_FIN, 3'd0, 1'b1);
    tick(); chk("t4_idle", S_IDLE, 3'd0, 1'b0);

    // abort beats pause in RUN
    start = 1'b1; limit = 3'd4; reps = 4'd0;
    tick(); start = 1'b0;
    tick(); chk("t5_c1", S_RUN, 3'd1, 1'b0);
    abort = 1'b1; pause = 1'b1;
    tick(); abort = 1'b0; pause = 1'b0;
    chk("t5_abort_pause", S_IDLE, 3'd0, 1'b0);

    // reset while in HOLD at count 6, then restart on first post-reset edge
    start = 1'b1; limit = 3'd7; reps = 4'd0;
    tick(); start = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    chk("t6_c6", S_RUN, 3'd6, 1'b0);
    pause = 1'b1;
    tick(); chk("t6_hold", S_HOLD, 3'd6, 1'b0);
    reset = 1'b1;
    tick(); chk("t6_reset", S_IDLE, 3'd0, 1'b0);
    reset = 1'b0; pause = 1'b0; start = 1'b1; limit = 3'd2; reps = 4'd1;
    tick(); start = 1'b0;
    chk("t6_restart", S_RUN, 3'd0, 1'b0);
    tick(); chk("t6_c1", S_RUN, 3'd1, 1'b0);
    tick(); chk("t6_c2", S_RUN, 3'd2, 1'b0);
    tick(); chk("t6_fin", S_FIN, 3'd0, 1'b1);
    tick(); chk("t6_idle", S_IDLE, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
